ahb_mem_slave_ctrl: RTL and testbench

//  AHB-Lite slave front end that drives the synchronous slave1 memory (rdEn/wrEn/Addr/Datai in, Datao out).

---
 rtl/ahb_mem_slave_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ahb_mem_slave_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave_ctrl
//
// AHB-Lite slave front end for the synchronous slave1 memory. The block
// registers each accepted address phase and turns its data phase into a
// single-cycle memory strobe. Illegal transfers get the two-cycle ERROR
// response. Read data is returned from the memory.
//
// Parameters
//   SLAVE_ADDRWIDTH  memory word-address width
//   SLAVE_DATAWIDTH  memory / HWDATA / HRDATA width in bits (8, 16 or 32)
//
// Ports
//   clk        in   system clock, all state on posedge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select from the decoder
//   HADDR      in   transfer address (32 bits)
//   HTRANS     in   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   HWRITE     in   1=write 0=read
//   HSIZE      in   transfer size
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus-level ready (previous transfer completing)
//   HRDATA     out  read data (data phase), '0 outside a read data phase
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0=OKAY 1=ERROR
//   rdEn       out  memory read strobe
//   wrEn       out  memory write strobe
//   Addr       out  memory word address (holds its last value when idle)
//   Datai      out  memory write data (= HWDATA)
//   Datao      in   memory read data (tri-stated by the memory when not reading)
//
// Configuration macro
//   AHB_MEM_RD_WAIT_EN  when defined, each legal read passes through RWAIT
//                       (one wait state). HRDATA is then served from a
//                       register loaded in RWAIT. When it is undefined,
//                       reads are zero-wait and HRDATA is combinational
//                       from Datao.
// ---------------------------------------------------------------------------
module ahb_mem_slave_ctrl #(
    parameter int SLAVE_ADDRWIDTH = 8,
    parameter int SLAVE_DATAWIDTH = 8
) (
    input  logic                       clk,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [31:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [SLAVE_DATAWIDTH-1:0] HWDATA,
    input  logic                       HREADY,
    output logic [SLAVE_DATAWIDTH-1:0] HRDATA,
    output logic                       HREADYOUT,
    output logic                       HRESP,
    output logic                       rdEn,
    output logic                       wrEn,
    output logic [SLAVE_ADDRWIDTH-1:0] Addr,
    output logic [SLAVE_DATAWIDTH-1:0] Datai,
    input  logic [SLAVE_DATAWIDTH-1:0] Datao
);

    // Byte-lane shift: number of HADDR bits that select a byte inside a word.
    localparam int          SH         = $clog2(SLAVE_DATAWIDTH / 8);
    localparam logic [2:0]  LEGAL_SIZE = 3'(SH);
    localparam logic [31:0] LOW_MASK   = (32'd1 << SH) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // no data phase in progress
        S_WR   = 3'd1,   // write data phase
        S_RD   = 3'd2,   // read data phase
        S_ERR1 = 3'd3,   // first ERROR cycle (wait state)
        S_ERR2 = 3'd4    // second ERROR cycle (completing)
`ifdef AHB_MEM_RD_WAIT_EN
        , S_RWAIT = 3'd5 // read wait state, memory being read
`endif
    } state_t;

    state_t                       state_q, state_d;
    logic [SLAVE_ADDRWIDTH-1:0]   addr_q, addr_d;
    logic                         accept;
    logic                         legal;

    // A transfer is ours only when selected, the bus is ready and it is
    // NONSEQ/SEQ. IDLE/BUSY slots simply complete with a zero-wait OKAY.
    assign accept = HSEL & HREADY & HTRANS[1];

    // Only full-width, naturally aligned accesses are supported.
    assign legal  = (HSIZE == LEGAL_SIZE) && ((HADDR & LOW_MASK) == 32'd0);

    // HTRANS[0] only separates IDLE from BUSY and SEQ from NONSEQ, which this
    // slave treats alike.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // -----------------------------------------------------------------------
    // State and captured address
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register samples the pre-edge values of every other register.
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef AHB_MEM_RD_WAIT_EN
    // Read data is captured while the memory is strobed in RWAIT. During RD
    // it is then presented from a flop and not through the memory path.
    logic [SLAVE_DATAWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: this is a single datapath register, not a memory array,
            // so resetting it is cheap. It also keeps HRDATA free of X after
            // reset.
            rd_data_q <= '0;
        end else if (state_q == S_RWAIT) begin
            rd_data_q <= Datao;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. No path can
        // then leave a signal unassigned, so no latch is inferred.
        state_d   = state_q;
        addr_d    = addr_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        rdEn      = 1'b0;
        wrEn      = 1'b0;
        HRDATA    = '0;

        // Data-phase outputs, decided by the transfer currently in flight.
        case (state_q)
            S_WR: begin
                wrEn = 1'b1;
            end
            S_RD: begin
                rdEn = 1'b1;
`ifdef AHB_MEM_RD_WAIT_EN
                HRDATA = rd_data_q;
`else
                HRDATA = Datao;
`endif
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: begin
                HRESP = 1'b1;
            end
`ifdef AHB_MEM_RD_WAIT_EN
            S_RWAIT: begin
                HREADYOUT = 1'b0;
                rdEn      = 1'b1;
            end
`endif
            default: ;
        endcase

        // Next state. The first ERROR cycle (and RWAIT) holds the bus, so no
        // address phase can complete there. Every other state ends its data
        // phase in this cycle, and the next state comes from the address
        // phase being accepted now.
        case (state_q)
            S_ERR1: state_d = S_ERR2;
`ifdef AHB_MEM_RD_WAIT_EN
            S_RWAIT: state_d = S_RD;
`endif
            default: begin
                if (accept) begin
                    // Upper HADDR bits are dropped; aliasing is the decoder's
                    // business.
                    addr_d = HADDR[SLAVE_ADDRWIDTH-1+SH:SH];
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else if (HWRITE) begin
                        state_d = S_WR;
                    end else begin
`ifdef AHB_MEM_RD_WAIT_EN
                        state_d = S_RWAIT;
`else
                        state_d = S_RD;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // The memory address comes straight from the captured register, so it is
    // glitch-free during the strobe and holds its value between transfers.
    assign Addr  = addr_q;
    // HWDATA is only valid in the write data phase. wrEn qualifies it.
    assign Datai = HWDATA;

endmodule

// File: tb/tb_ahb_mem_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_slave_ctrl
//
// Self-checking bench for ahb_mem_slave_ctrl (SLAVE_DATAWIDTH=8,
// SLAVE_ADDRWIDTH=8). It contains:
//   - a behavioural slave1 memory: combinational read while rdEn, write on
//     posedge while wrEn, and a junk value on Datao when not reading;
//   - a table of single-transfer vectors;
//   - hand-written sequences: back-to-back write/read, the ERROR response,
//     and reset during a write;
//   - a randomized pipelined phase checked against a transaction-level
//     model (a queue of expected data-phase cycles plus a memory array).
// AHB_MEM_RD_WAIT_EN is honoured when defined for the bench as well.
// ---------------------------------------------------------------------------
module tb_ahb_mem_slave_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int SH    = $clog2(DW / 8);
    localparam int NRAND = 600;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic          clk = 1'b0;
    logic          hresetn;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic [DW-1:0] hrdata;
    logic          hreadyout;
    logic          hresp;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] datai;
    logic [DW-1:0] datao;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_mem_slave_ctrl #(
        .SLAVE_ADDRWIDTH(AW),
        .SLAVE_DATAWIDTH(DW)
    ) dut (
        .clk      (clk),
        .HRESETn  (hresetn),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (hready),
        .HRDATA   (hrdata),
        .HREADYOUT(hreadyout),
        .HRESP    (hresp),
        .rdEn     (rd_en),
        .wrEn     (wr_en),
        .Addr     (addr),
        .Datai    (datai),
        .Datao    (datao)
    );

    // ---------------- slave1 memory (the device being driven) --------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign datao = rd_en ? mem[addr] : 8'hEE;
    always @(posedge clk) if (wr_en) mem[addr] <= datai;

    // ---------------- reference model state -------------------------------
    logic [DW-1:0] mem_model [0:(1<<AW)-1];

    // One expected data-phase cycle.
    typedef struct packed {
        logic          ready;
        logic          resp;
        logic          rd;
        logic          wr;
        logic          show;   // HRDATA carries memory data this cycle
        logic [AW-1:0] addr;
    } cyc_t;
    cyc_t exp_q[$];

    typedef struct {
        string         name;
        logic          hsel;
        logic [1:0]    htrans;
        logic          hwrite;
        logic [31:0]   haddr;
        logic [2:0]    hsize;
        logic          hready;
        logic [DW-1:0] hwdata;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_hrdata;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [DW-1:0] mem_init(input int a);
        return DW'(a ^ 'h5A);
    endfunction

    function automatic cyc_t mk(input logic r, input logic s, input logic rd,
                                input logic wr, input logic show,
                                input logic [AW-1:0] a);
        cyc_t c;
        c = '{ready: r, resp: s, rd: rd, wr: wr, show: show, addr: a};
        return c;
    endfunction

    // ---------------- helpers ---------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic sel, input logic [1:0] trans,
                              input logic wr, input logic [31:0] a,
                              input logic [2:0] sz);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic drive_idle();
        drive_addr(1'b0, T_IDLE, 1'b0, 32'h0, 3'(SH));
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic e_ready,
                              input logic e_resp, input logic e_rd,
                              input logic e_wr, input logic [DW-1:0] e_data);
        checks++;
        if ({hreadyout, hresp, rd_en, wr_en, hrdata} !==
            {e_ready, e_resp, e_rd, e_wr, e_data}) begin
            errors++;
            $display("FAIL %s: got rdy=%b resp=%b rd=%b wr=%b hrdata=%h, expected rdy=%b resp=%b rd=%b wr=%b hrdata=%h",
                     name, hreadyout, hresp, rd_en, wr_en, hrdata,
                     e_ready, e_resp, e_rd, e_wr, e_data);
        end
    endtask

    // With the read wait state compiled in, a legal read first spends one
    // cycle stalled with the strobe up and HRDATA still zero.
    task automatic skip_rd_wait(input string name);
`ifdef AHB_MEM_RD_WAIT_EN
        @(negedge clk);
        check_outs(name, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        step();
`else
        name = name;
`endif
    endtask

    // ---------------- watchdog --------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- main test -------------------------------------------
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]       = mem_init(i);
            mem_model[i] = mem_init(i);
        end

        // Reset values
        hresetn = 1'b0;
        hready  = 1'b1;
        hwdata  = '0;
        drive_idle();
        step();
        step();
        @(negedge clk);
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("reset_addr", addr, 0);
        step();
        hresetn = 1'b1;

        // ---------------- table-driven single transfers -------------------
        //            name      sel  trans     wr    haddr          size   rdy   wdata  rd wr  addr   hrdata
        vecs[0] = '{"wr10",   1'b1, T_NONSEQ, 1'b1, 32'h0000_0010, 3'd0, 1'b1, 8'hA5, 0, 1, 8'h10, 8'h00};
        vecs[1] = '{"rd10",   1'b1, T_NONSEQ, 1'b0, 32'h0000_0010, 3'd0, 1'b1, 8'h00, 1, 0, 8'h10, 8'hA5};
        vecs[2] = '{"idle",   1'b1, T_IDLE,   1'b1, 32'h0000_0010, 3'd0, 1'b1, 8'h11, 0, 0, 8'h00, 8'h00};
        vecs[3] = '{"busy",   1'b1, T_BUSY,   1'b1, 32'h0000_0044, 3'd0, 1'b1, 8'h22, 0, 0, 8'h00, 8'h00};
        vecs[4] = '{"nosel",  1'b0, T_NONSEQ, 1'b1, 32'h0000_0044, 3'd0, 1'b1, 8'h33, 0, 0, 8'h00, 8'h00};
        vecs[5] = '{"nordy",  1'b1, T_NONSEQ, 1'b1, 32'h0000_0044, 3'd0, 1'b0, 8'h44, 0, 0, 8'h00, 8'h00};
        vecs[6] = '{"seqwr",  1'b1, T_SEQ,    1'b1, 32'hFFFF_FF11, 3'd0, 1'b1, 8'h5C, 0, 1, 8'h11, 8'h00};
        vecs[7] = '{"rd11",   1'b1, T_SEQ,    1'b0, 32'h0000_0311, 3'd0, 1'b1, 8'h00, 1, 0, 8'h11, 8'h5C};
        vecs[8] = '{"rd44",   1'b1, T_NONSEQ, 1'b0, 32'h0000_0044, 3'd0, 1'b1, 8'h00, 1, 0, 8'h44, mem_init('h44)};

        for (int i = 0; i < 9; i++) begin
            drive_addr(vecs[i].hsel, vecs[i].htrans, vecs[i].hwrite,
                       vecs[i].haddr, vecs[i].hsize);
            hready = vecs[i].hready;
            step();
            hready = 1'b1;
            hwdata = vecs[i].hwdata;
            drive_idle();
            if (vecs[i].e_rd) skip_rd_wait({vecs[i].name, "_wait"});
            @(negedge clk);
            check_outs(vecs[i].name, 1'b1, 1'b0, vecs[i].e_rd, vecs[i].e_wr,
                       vecs[i].e_hrdata);
            if (vecs[i].e_rd | vecs[i].e_wr)
                check({vecs[i].name, "_addr"}, addr, vecs[i].e_addr);
            if (vecs[i].e_wr) begin
                check({vecs[i].name, "_datai"}, datai, vecs[i].hwdata);
                mem_model[vecs[i].e_addr] = vecs[i].hwdata;
            end
            step();
        end

        // ---------------- back-to-back write then read of 0x20 ------------
        drive_addr(1'b1, T_NONSEQ, 1'b1, 32'h20, 3'd0);
        step();
        hwdata = 8'h3C;
        drive_addr(1'b1, T_NONSEQ, 1'b0, 32'h20, 3'd0);
        @(negedge clk);
        check_outs("b2b_wr", 1'b1, 1'b0, 1'b0, 1'b1, '0);
        check("b2b_wr_datai", datai, 8'h3C);
        step();
        mem_model[8'h20] = 8'h3C;
        hwdata = '0;
        drive_idle();
        skip_rd_wait("b2b_wait");
        @(negedge clk);
        check_outs("b2b_rd", 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
        check("b2b_rd_addr", addr, 8'h20);
        step();

        // ---------------- illegal size: two-cycle ERROR -------------------
        drive_addr(1'b1, T_NONSEQ, 1'b1, 32'h04, 3'b010);
        step();
        hwdata = 8'hFF;
        drive_idle();
        @(negedge clk);
        check_outs("err1", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step();
        // A new address phase is accepted during the second ERROR cycle.
        drive_addr(1'b1, T_NONSEQ, 1'b0, 32'h04, 3'd0);
        @(negedge clk);
        check_outs("err2", 1'b1, 1'b1, 1'b0, 1'b0, '0);
        step();
        drive_idle();
        skip_rd_wait("err_rd_wait");
        @(negedge clk);
        check_outs("err_rd04", 1'b1, 1'b0, 1'b1, 1'b0, mem_model[8'h04]);
        step();

        // ---------------- reset during a write data phase -----------------
        drive_addr(1'b1, T_NONSEQ, 1'b1, 32'h30, 3'd0);
        step();
        hwdata = 8'h77;
        drive_idle();
        @(negedge clk);
        check_outs("rstw_pre", 1'b1, 1'b0, 1'b0, 1'b1, '0);
        #1 hresetn = 1'b0;
        #1;
        check_outs("rstw_now", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rstw_addr", addr, 0);
        step();
        step();
        hresetn = 1'b1;
        step();
        drive_addr(1'b1, T_NONSEQ, 1'b0, 32'h30, 3'd0);
        step();
        drive_idle();
        skip_rd_wait("rstw_wait");
        @(negedge clk);
        check_outs("rstw_old", 1'b1, 1'b0, 1'b1, 1'b0, mem_model[8'h30]);
        step();

        // ---------------- randomized pipelined traffic --------------------
        exp_q.delete();
        for (int c = 0; c < NRAND; c++) begin
            cyc_t          cur;
            logic          acc;
            logic          lg;
            logic [AW-1:0] word;
            logic [DW-1:0] e_data;

            cur = (exp_q.size() != 0) ? exp_q[0] : mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            hready = cur.ready;
            hwdata = DW'($urandom);
            hsel   = ($urandom_range(0, 7) != 0);
            htrans = 2'($urandom_range(0, 3));
            hwrite = 1'($urandom_range(0, 1));
            haddr  = {24'($urandom), 8'($urandom_range(0, 15))};
            hsize  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'(SH);
            @(negedge clk);
            e_data = cur.show ? mem_model[cur.addr] : '0;
            check_outs("rand", cur.ready, cur.resp, cur.rd, cur.wr, e_data);
            if (cur.rd | cur.wr) check("rand_addr", addr, cur.addr);
            if (cur.wr) begin
                check("rand_datai", datai, hwdata);
                mem_model[cur.addr] = hwdata;
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());

            acc  = hsel & hready & htrans[1];
            lg   = (hsize == 3'(SH)) && ((haddr % (DW / 8)) == 0);
            word = AW'(haddr >> SH);
            if (acc) begin
                if (!lg) begin
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, word));
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, word));
                end else if (hwrite) begin
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, word));
                end else begin
`ifdef AHB_MEM_RD_WAIT_EN
                    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, word));
`endif
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, word));
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
